matrix_result_accum_4x4x16: RTL and testbench
=============================================

// Module: matrix_result_accum_4x4x16
// PURPOSE
//  Downstream stage of the 4x4x4x16 matrix multiplier. Accumulates K successive 4x4 tiles of
//  signed 32-bit results, then requantizes (round, optional ReLU, saturate) to signed 16-bit.
//  Drains the result one row per valid/ready handshake, in the row layout the activation loader expects.
// PARAMETERS
//  ACC_W       40  accumulator width per element (32 + TILE_CNT_W, so 255 tiles never overflow)
//  OUT_W       16  output element width, signed
//  TILE_CNT_W  8   width of k_tiles
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-low; clears all state
//  in_valid     in   1           in_results holds a valid tile
//  in_ready     out  1           block accepts a tile this cycle
//  in_results   in   4x4x32      signed [31:0] [0:3][0:3] partial-product tile from the multiplier
//  k_tiles      in   TILE_CNT_W  number of tiles to accumulate; sampled on the first tile of a block; 0 is treated as 1
//  shift        in   5           arithmetic right-shift amount; sampled on the first tile
//  relu_en      in   1           clamp negatives to 0; sampled on the first tile
//  out_valid    out  1           out_row is valid
//  out_ready    in   1           consumer accepts out_row
//  out_row      out  4x16        signed [15:0] [0:3], requantized row out_row_idx
//  out_row_idx  out  2           row index 0..3
//  out_last     out  1           high with row 3
//  busy         out  1           high in ACCUM or DRAIN
//  sat_flag     out  1           some element of the current block saturated; cleared on the next block's first tile
// BEHAVIOUR
//  Reset values: in_ready=0 while reset is low; out_valid, out_row, out_row_idx, out_last, busy, sat_flag,
//  accumulators, counters are all 0. FSM enters IDLE.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE. A tile is accepted when in_valid && in_ready.
//  IDLE:  in_ready=1. On accept:
//         - acc[r][c] <= sign-extended in_results[r][c] (overwrite, not add)
//         - latch k_tiles (0->1), shift and relu_en; cnt <= 1; clear sat_flag
//         - if k==1 go to DRAIN, else go to ACCUM
//  ACCUM: in_ready=1. On accept: acc += sign-extended tile; cnt++. Go to DRAIN when the accepted tile makes cnt==k.
//         No timeout; in_valid gaps are allowed.
//  DRAIN: in_ready=0. Tiles presented during DRAIN are not consumed.
//  Latency: the final tile accepted at edge N gives out_valid=1, row 0 after edge N+1.
//  Requant per element, combinational from acc into the registered out_row:
//         - v = (acc + (shift ? 1<<(shift-1) : 0)) >>> shift   (round half up, ACC_W+1 bits)
//         - if relu_en and v<0, v = 0
//         - saturate to [-32768, 32767]; any clamp sets sat_flag for the rest of the block
//  Drain: out_row, out_row_idx and out_last stay stable while out_valid && !out_ready.
//         - each handshake advances the row
//         - handshake on row 3 (out_last=1) clears out_valid and returns to IDLE
//         - in_ready rises the cycle after that handshake; no tile is accepted in the same cycle
//  Reset low mid-operation: the block is discarded immediately; no partial output is emitted.
//  After release, the first accepted tile starts a fresh block.
// TESTING
//  T1 k=1, shift=0, relu=0, results[r][c]=4r+c -> rows {0,1,2,3},{4..7},{8..11},{12..15};
//     out_valid 1 cycle after accept; out_last on row 3.
//  T2 k=3, all elements 1000, shift=4 -> every out element 188 ((3000+8)>>4); busy high from first accept to last drain.
//  T3 k=2, elements +2^30 -> 32767 and sat_flag=1; elements -2^30 -> -32768; mixed tile clamps per element only.
//  T4 k=1, element -5: relu_en=1 -> 0; relu_en=0 -> -5. shift=1 on 3 -> 2 and on -3 -> -1 (round half up).
//  T5 out_ready held low 5 cycles at row 1 -> out_row, out_row_idx=1 and out_valid held;
//     in_ready=0; in_valid tiles not consumed.
//  T6 k=3: reset low after tile 1 -> outputs 0; release, feed a k=1 tile of 7s -> output all 7 (no stale sum).

Source files
------------

// File: rtl/matrix_result_accum_4x4x16.sv
// Accumulates K signed 32-bit 4x4 tiles and requantizes them to signed 16-bit.
// The result drains one row per valid/ready handshake.
module matrix_result_accum_4x4x16 #(
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int TILE_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [0:3][0:3][31:0]       in_results,
  input  logic [TILE_CNT_W-1:0]       k_tiles,
  input  logic [4:0]                  shift,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [0:3][OUT_W-1:0]       out_row,
  output logic [1:0]                  out_row_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        sat_flag
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                        state, state_nxt;
  logic [0:3][0:3][ACC_W-1:0]    acc;
  logic [TILE_CNT_W-1:0]         k_q, cnt, cnt_inc;
  logic [4:0]                    sh_q;
  logic                          relu_q;
  logic                          accept, k_one, drain_done, load_row;
  logic [1:0]                    nxt_idx;
  logic [0:3][OUT_W-1:0]         nxt_row;
  logic                          row_sat;
  logic [ACC_W:0]                rnd;
  logic signed [ACC_W:0]         rq_sum [0:3];
  logic signed [ACC_W:0]         rq_v   [0:3];

  function automatic logic [ACC_W-1:0] sext(input logic [31:0] x);
    return {{(ACC_W-32){x[31]}}, x};
  endfunction

  // Gated by reset so the block never advertises readiness while held in reset.
  assign in_ready   = reset && (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign cnt_inc    = cnt + TILE_CNT_W'(1);
  assign k_one      = (k_tiles <= TILE_CNT_W'(1));
  assign drain_done = out_valid && out_ready && out_last;
  assign load_row   = (state == DRAIN) && (!out_valid || (out_ready && !out_last));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = k_one ? DRAIN : ACCUM;
      ACCUM:   if (accept && (cnt_inc == k_q)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requantize the row about to be presented: round half up, ReLU, saturate.
  assign nxt_idx = out_valid ? out_row_idx + 2'd1 : 2'd0;
  assign rnd     = (sh_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (sh_q - 5'd1));

  always_comb begin
    row_sat = 1'b0;
    nxt_row = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      rq_sum[c] = $signed({acc[nxt_idx][c][ACC_W-1], acc[nxt_idx][c]}) + $signed(rnd);
      rq_v[c]   = rq_sum[c] >>> sh_q;
      if (relu_q && rq_v[c][ACC_W]) rq_v[c] = '0;
      if (rq_v[c][ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){rq_v[c][ACC_W]}}) begin
        row_sat    = 1'b1;
        nxt_row[c] = rq_v[c][ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        nxt_row[c] = rq_v[c][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      k_q         <= '0;
      cnt         <= '0;
      sh_q        <= '0;
      relu_q      <= 1'b0;
      sat_flag    <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned r = 0; r < 4; r++)
          for (int unsigned c = 0; c < 4; c++)
            acc[r][c] <= (state == IDLE) ? sext(in_results[r][c])
                                         : acc[r][c] + sext(in_results[r][c]);
        if (state == IDLE) begin
          k_q      <= k_one ? TILE_CNT_W'(1) : k_tiles;
          sh_q     <= shift;
          relu_q   <= relu_en;
          cnt      <= TILE_CNT_W'(1);
          sat_flag <= 1'b0;
        end else begin
          cnt <= cnt_inc;
        end
      end
      if (load_row) begin
        out_valid   <= 1'b1;
        out_row     <= nxt_row;
        out_row_idx <= nxt_idx;
        out_last    <= (nxt_idx == 2'd3);
        if (row_sat) sat_flag <= 1'b1;
      end else if ((state == DRAIN) && drain_done) begin
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
        out_row_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_accum_4x4x16.sv
// Directed bench for matrix_result_accum_4x4x16 with hand-computed expectations.
module tb_matrix_result_accum_4x4x16;

  typedef logic [0:3][0:3][31:0] tile_t;
  typedef logic [0:3][15:0]      row_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  tile_t       in_results;
  logic [7:0]  k_tiles;
  logic [4:0]  shift;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  row_t        out_row;
  logic [1:0]  out_row_idx;
  logic        out_last;
  logic        busy;
  logic        sat_flag;

  int checks = 0;
  int passed = 0;

  row_t got_row  [4];
  int   got_idx  [4];
  logic got_last [4];
  int   got_n;

  matrix_result_accum_4x4x16 #(.ACC_W(40), .OUT_W(16), .TILE_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_results(in_results), .k_tiles(k_tiles), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic tile_t fill(input int v);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = 32'(v);
    return t;
  endfunction

  function automatic row_t frow(input int v);
    row_t x;
    for (int c = 0; c < 4; c++) x[c] = 16'(v);
    return x;
  endfunction

  task automatic send_tile(input tile_t t, input int k, input int sh, input bit relu);
    int b;
    in_results = t; k_tiles = 8'(k); shift = 5'(sh); relu_en = relu; in_valid = 1'b1;
    b = 0;
    while (!in_ready && b < 50) begin @(posedge clk); #1; b++; end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_tile: in_ready stayed 0 for %0d cycles, required 1", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b;
    out_ready = 1'b1; got_n = 0; b = 0;
    while (got_n < 4 && b < budget) begin
      if (out_valid) begin
        got_row[got_n] = out_row; got_idx[got_n] = int'(out_row_idx);
        got_last[got_n] = out_last; got_n++;
      end
      @(posedge clk); #1; b++;
      if (got_n > 0 && got_last[got_n-1]) break;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_results = '0;
    k_tiles = '0; shift = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    checks++; if ({out_valid, out_last, busy, sat_flag} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {out_valid, out_last, busy, sat_flag}); else passed++;
    checks++; if (out_row !== '0 || out_row_idx !== 2'd0)
      $display("FAIL reset_row: got %h idx %0d want 0", out_row, out_row_idx); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_single_tile;
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = 32'(4 * r + c);
    out_ready = 1'b1;
    send_tile(t, 1, 0, 1'b0);
    checks++; if ({out_valid, busy, in_ready} !== 3'b010)
      $display("FAIL t1_after_accept: got v/busy/rdy %b want 010", {out_valid, busy, in_ready}); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_row_idx !== 2'd0)
      $display("FAIL t1_latency: got valid %b idx %0d want 1 0", out_valid, out_row_idx); else passed++;
    drain(20);
    checks++; if (got_n !== 4) $display("FAIL t1_rows: got %0d want 4", got_n); else passed++;
    for (int r = 0; r < 4; r++) begin
      row_t e;
      for (int c = 0; c < 4; c++) e[c] = 16'(4 * r + c);
      checks++; if (got_row[r] !== e || got_idx[r] !== r)
        $display("FAIL t1_row%0d: got %h idx %0d want %h idx %0d", r, got_row[r], got_idx[r], e, r); else passed++;
    end
    checks++; if ({got_last[0], got_last[1], got_last[2], got_last[3]} !== 4'b0001)
      $display("FAIL t1_last: got %b want 0001", {got_last[0], got_last[1], got_last[2], got_last[3]}); else passed++;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL t1_idle: got busy %b rdy %b valid %b want 0 1 0", busy, in_ready, out_valid); else passed++;
  endtask

  task automatic test_accum_round;
    send_tile(fill(1000), 3, 4, 1'b0);
    checks++; if ({busy, in_ready, out_valid} !== 3'b110)
      $display("FAIL t2_tile1: got busy/rdy/valid %b want 110", {busy, in_ready, out_valid}); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL t2_gap: got busy %b valid %b want 1 0", busy, out_valid); else passed++;
    send_tile(fill(1000), 9, 0, 1'b1);
    send_tile(fill(1000), 9, 0, 1'b1);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL t2_drain_state: got busy %b rdy %b want 1 0", busy, in_ready); else passed++;
    @(posedge clk); #1;
    drain(20);
    checks++; if (got_n !== 4) $display("FAIL t2_rows: got %0d want 4", got_n); else passed++;
    for (int r = 0; r < 4; r++) begin
      checks++; if (got_row[r] !== frow(188))
        $display("FAIL t2_row%0d: got %h want %h", r, got_row[r], frow(188)); else passed++;
    end
    checks++; if (sat_flag !== 1'b0 || busy !== 1'b0)
      $display("FAIL t2_end: got sat %b busy %b want 0 0", sat_flag, busy); else passed++;
  endtask

  task automatic test_saturate;
    tile_t t;
    row_t  e0;
    send_tile(fill(32'h4000_0000), 2, 0, 1'b0);
    send_tile(fill(32'h4000_0000), 2, 0, 1'b0);
    @(posedge clk); #1;
    drain(20);
    checks++; if (got_n !== 4 || got_row[0] !== frow(32767) || got_row[3] !== frow(32767))
      $display("FAIL t3_pos: got n %0d r0 %h r3 %h want 4 %h", got_n, got_row[0], got_row[3], frow(32767)); else passed++;
    checks++; if (sat_flag !== 1'b1) $display("FAIL t3_pos_sat: got %b want 1", sat_flag); else passed++;
    send_tile(fill(-32'sh4000_0000), 2, 0, 1'b0);
    checks++; if (sat_flag !== 1'b0) $display("FAIL t3_sat_clear: got %b want 0", sat_flag); else passed++;
    send_tile(fill(-32'sh4000_0000), 2, 0, 1'b0);
    @(posedge clk); #1;
    drain(20);
    checks++; if (got_n !== 4 || got_row[1] !== frow(-32768) || got_row[2] !== frow(-32768))
      $display("FAIL t3_neg: got n %0d r1 %h r2 %h want 4 %h", got_n, got_row[1], got_row[2], frow(-32768)); else passed++;
    checks++; if (sat_flag !== 1'b1) $display("FAIL t3_neg_sat: got %b want 1", sat_flag); else passed++;
    t = fill(5); t[0][0] = 32'h4000_0000;
    e0 = frow(10); e0[0] = 16'h7FFF;
    send_tile(t, 2, 0, 1'b0);
    send_tile(t, 2, 0, 1'b0);
    @(posedge clk); #1;
    drain(20);
    checks++; if (got_row[0] !== e0 || got_row[1] !== frow(10) || got_row[3] !== frow(10))
      $display("FAIL t3_mixed: got r0 %h r1 %h r3 %h want %h %h", got_row[0], got_row[1], got_row[3], e0, frow(10)); else passed++;
    checks++; if (sat_flag !== 1'b1) $display("FAIL t3_mixed_sat: got %b want 1", sat_flag); else passed++;
  endtask

  task automatic test_relu_round;
    int vals [4] = '{-5, -5, 3, -3};
    int ks   [4] = '{1, 0, 1, 1};
    int shs  [4] = '{0, 0, 1, 1};
    bit rl   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int exps [4] = '{0, -5, 2, -1};
    for (int i = 0; i < 4; i++) begin
      send_tile(fill(vals[i]), ks[i], shs[i], rl[i]);
      @(posedge clk); #1;
      drain(20);
      checks++; if (got_n !== 4 || got_row[0] !== frow(exps[i]) || got_row[3] !== frow(exps[i]))
        $display("FAIL t4_case%0d: got n %0d r0 %h r3 %h want 4 %h", i, got_n, got_row[0], got_row[3], frow(exps[i])); else passed++;
      checks++; if (sat_flag !== 1'b0) $display("FAIL t4_sat%0d: got %b want 0", i, sat_flag); else passed++;
    end
  endtask

  task automatic test_backpressure;
    tile_t t;
    row_t  e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = 32'(10 * r + c);
    out_ready = 1'b0;
    send_tile(t, 1, 0, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_row_idx !== 2'd0)
      $display("FAIL t5_row0: got valid %b idx %0d want 1 0", out_valid, out_row_idx); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) e[c] = 16'(10 + c);
    in_results = fill(99); k_tiles = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_row_idx !== 2'd1 || out_row !== e || in_ready !== 1'b0)
        $display("FAIL t5_stall%0d: got valid %b idx %0d row %h rdy %b want 1 1 %h 0",
                 i, out_valid, out_row_idx, out_row, in_ready, e); else passed++;
    end
    in_valid = 1'b0;
    drain(20);
    checks++; if (got_n !== 3 || got_idx[0] !== 1 || got_idx[2] !== 3 || got_last[2] !== 1'b1)
      $display("FAIL t5_rest: got n %0d idx %0d..%0d last %b want 3 1..3 1", got_n, got_idx[0], got_idx[2], got_last[2]); else passed++;
    for (int c = 0; c < 4; c++) e[c] = 16'(30 + c);
    checks++; if (got_row[2] !== e) $display("FAIL t5_row3: got %h want %h", got_row[2], e); else passed++;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL t5_idle: got busy %b valid %b want 0 0", busy, out_valid); else passed++;
  endtask

  task automatic test_reset_mid_block;
    send_tile(fill(1000), 3, 0, 1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL t6_busy: got %b want 1", busy); else passed++;
    reset = 1'b0;
    #1;
    checks++; if ({out_valid, busy, in_ready, sat_flag} !== 4'b0 || out_row !== '0)
      $display("FAIL t6_in_reset: got v/busy/rdy/sat %b row %h want 0000 0",
               {out_valid, busy, in_ready, sat_flag}, out_row); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_tile(fill(7), 1, 0, 1'b0);
    @(posedge clk); #1;
    drain(20);
    checks++; if (got_n !== 4 || got_row[0] !== frow(7) || got_row[3] !== frow(7))
      $display("FAIL t6_fresh: got n %0d r0 %h r3 %h want 4 %h", got_n, got_row[0], got_row[3], frow(7)); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_tile;
    test_accum_round;
    test_saturate;
    test_relu_round;
    test_backpressure;
    test_reset_mid_block;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
